// File: rtl/fpuprod_sched_pkg.sv
// Shared constants and the pipe entry that rides alongside the multiplier.
// The entry is sized for the largest supported NREQ (16) and TAGW (16).
package fpuprod_pkg;

  localparam int FP_W      = 64;
  localparam int EXP_LSB   = 53;
  localparam int EXP_W     = 10;
  localparam logic [EXP_W-1:0] BIAS = 10'h200;
  localparam int ID_MAX_W  = 4;
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [ID_MAX_W-1:0]  id;
    logic [TAG_MAX_W-1:0] tag;
    logic                 pookg;
  } pipe_entry_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fpuprod_sched_if.sv
// Request/response bus between requesters and the multiplier scheduler.
interface fpuprod_sched_if
  import fpuprod_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 4
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*FP_W-1:0] req_A;
  logic [NREQ*FP_W-1:0] req_B;
  logic [NREQ-1:0]      req_rnd;
  logic [NREQ-1:0]      req_pookg;
  logic [NREQ*TAGW-1:0] req_tag;

  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic [FP_W-1:0]      rsp_res;

  modport master (
    output req_valid, req_A, req_B, req_rnd, req_pookg, req_tag,
    input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_res
  );

  modport slave (
    input  req_valid, req_A, req_B, req_rnd, req_pookg, req_tag,
    output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_res
  );
endinterface

// File: rtl/fpuprod_sched_rr_arb.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
module rr_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Scan from ptr; the first hit latches idx and blocks later candidates
  always_comb begin
    logic [IDW-1:0] cand;
    logic           hit;
    int             sum;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    hit   = 1'b0;
    sum   = 0;
    for (int k = 0; k < NREQ; k++) begin
      sum         = int'(ptr) + k;
      cand        = (sum >= NREQ) ? IDW'(sum - NREQ) : IDW'(sum);
      hit         = !any && req[cand];
      grant[cand] = grant[cand] | hit;
      idx         = hit ? cand : idx;
      any         = any | hit;
    end
  end

endmodule

// File: rtl/fpuprod_sched.sv
// Shares one fixed-latency multiplier among NREQ requesters, carrying id/tag
// through a shift register so each product returns on a broadcast bus.
module fpuprod_sched
  import fpuprod_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int TAGW  = 4,
  parameter  int LAT   = 2,
  localparam int IDW   = $clog2(NREQ),
  localparam int INF_W = $clog2(LAT + 2)
) (
  input  logic             clk,
  input  logic             rst,
  fpuprod_sched_if.slave   bus,
  input  logic             flush,
  output logic [FP_W-1:0]  mul_A,
  output logic [FP_W-1:0]  mul_B,
  output logic             mul_rnd,
  output logic             mul_pookg,
  input  logic [FP_W-1:0]  mul_res,
  output logic [INF_W-1:0] inflight,
  output logic             busy
);

  logic [IDW-1:0]  rr_ptr_r;
  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  win_idx_s;
  logic            any_s;
  logic            xfer_s;
  logic            ret_s;
  logic [FP_W-1:0] sel_a_s;
  logic [FP_W-1:0] sel_b_s;
  logic            sel_rnd_s;
  logic            sel_pookg_s;
  logic [TAGW-1:0] sel_tag_s;
  pipe_entry_t     new_entry_s;
  pipe_entry_t     stage_r [LAT+1];

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .idx   (win_idx_s),
    .any   (any_s)
  );

  // Reset also masks grants so nothing looks accepted while the pipe is held
  assign bus.req_ready = (rst || flush) ? '0 : grant_s;
  assign xfer_s        = any_s && !flush;
  assign ret_s         = stage_r[LAT].valid;

  // Winner's operand/side-band mux
  always_comb begin
    sel_a_s     = '0;
    sel_b_s     = '0;
    sel_rnd_s   = 1'b0;
    sel_pookg_s = 1'b0;
    sel_tag_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a_s     = (win_idx_s == IDW'(i)) ? bus.req_A[i*FP_W +: FP_W] : sel_a_s;
      sel_b_s     = (win_idx_s == IDW'(i)) ? bus.req_B[i*FP_W +: FP_W] : sel_b_s;
      sel_rnd_s   = (win_idx_s == IDW'(i)) ? bus.req_rnd[i]            : sel_rnd_s;
      sel_pookg_s = (win_idx_s == IDW'(i)) ? bus.req_pookg[i]          : sel_pookg_s;
      sel_tag_s   = (win_idx_s == IDW'(i)) ? bus.req_tag[i*TAGW +: TAGW] : sel_tag_s;
    end
    new_entry_s = '{valid: 1'b1,
                    id:    ID_MAX_W'(win_idx_s),
                    tag:   TAG_MAX_W'(sel_tag_s),
                    pookg: sel_pookg_s};
  end

  // Round-robin pointer advances past the winner only on a real transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (xfer_s) begin
      rr_ptr_r <= IDW'(wrap_inc(int'(win_idx_s), NREQ));
    end
  end

  // Operand registers hold their last value between issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_A   <= '0;
      mul_B   <= '0;
      mul_rnd <= 1'b0;
    end else if (xfer_s) begin
      mul_A   <= sel_a_s;
      mul_B   <= sel_b_s;
      mul_rnd <= sel_rnd_s;
    end
  end

  // Side-band shift register; flush kills every in-flight valid at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LAT; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= xfer_s ? new_entry_s : '0;
      for (int i = 1; i <= LAT; i++) begin
        stage_r[i]       <= stage_r[i-1];
        stage_r[i].valid <= stage_r[i-1].valid && !flush;
      end
    end
  end

  // Issued-but-not-returned counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else begin
      case ({xfer_s, ret_s})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Last stage lines up with the multiplier's output mux
  assign mul_pookg     = stage_r[LAT].pookg;
  assign bus.rsp_valid = stage_r[LAT].valid;
  assign bus.rsp_id    = IDW'(stage_r[LAT].id);
  assign bus.rsp_tag   = TAGW'(stage_r[LAT].tag);
  assign bus.rsp_res   = mul_res;
  assign busy          = (inflight != '0) || (|bus.req_valid);

endmodule

// File: tb/tb_fpuprod_sched.sv
// Directed bench for fpuprod_sched with a two-stage behavioural multiplier.
module tb_fpuprod_sched;
  import fpuprod_pkg::*;

  localparam int NREQ = 4;
  localparam int TAGW = 4;
  localparam int LAT  = 2;

  localparam logic [63:0] ONE = 64'h4000000000000000;
  localparam logic [63:0] TWO = 64'h4020000000000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [63:0] mul_A, mul_B, mul_res;
  logic        mul_rnd, mul_pookg;
  logic [1:0]  inflight;
  logic        busy;
  logic [63:0] a_d1, a_d2, b_d1, b_d2;
  logic        rnd_d1, rnd_d2;
  logic [63:0] b_tab [4];

  int n_tests = 0;
  int n_fail  = 0;

  fpuprod_sched_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

  fpuprod_sched #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flush     (flush),
    .mul_A     (mul_A),
    .mul_B     (mul_B),
    .mul_rnd   (mul_rnd),
    .mul_pookg (mul_pookg),
    .mul_res   (mul_res),
    .inflight  (inflight),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b,
                                       input logic rnd, input logic pk);
    logic [107:0] p;
    logic [9:0]   e;
    logic [52:0]  m;
    p = 108'({1'b1, a[52:0]}) * 108'({1'b1, b[52:0]});
    e = a[62:53] + b[62:53] - BIAS;
    if (pk) begin
      e = e - 10'd53;
      m = p[52:0];
    end else if (p[107]) begin
      e = e + 10'd1;
      m = p[106:54];
    end else begin
      m = p[105:53];
    end
    m = m + 53'(rnd);
    return {a[63] ^ b[63], e, m};
  endfunction

  always @(posedge clk) begin
    a_d1   <= mul_A;
    a_d2   <= a_d1;
    b_d1   <= mul_B;
    b_d2   <= b_d1;
    rnd_d1 <= mul_rnd;
    rnd_d2 <= rnd_d1;
  end
  assign mul_res = fmul(a_d2, b_d2, rnd_d2, mul_pookg);

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] i, input logic [63:0] a, input logic [63:0] b,
                         input logic rnd, input logic pk, input logic [3:0] tag);
    bus.req_valid[i]            = 1'b1;
    bus.req_A[{i, 6'b0} +: 64]  = a;
    bus.req_B[{i, 6'b0} +: 64]  = b;
    bus.req_rnd[i]              = rnd;
    bus.req_pookg[i]            = pk;
    bus.req_tag[{i, 2'b0} +: 4] = tag;
  endtask

  task automatic clr_req(input logic [1:0] i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    b_tab = '{64'h4000000000000000, 64'h4020000000000000,
              64'h4040000000000000, 64'h4060000000000000};
    rst   = 1'b1;
    flush = 1'b0;
    bus.req_valid = '0; bus.req_A = '0; bus.req_B = '0;
    bus.req_rnd = '0; bus.req_pookg = '0; bus.req_tag = '0;
    for (int i = 0; i < 4; i++) set_req(2'(i), ONE, TWO, 1'b1, 1'b1, 4'(i));

    // Reset state, with every requester asking
    sample();
    check_eq("rst_ready",    64'(bus.req_ready), 64'h0);
    check_eq("rst_rsp_v",    64'(bus.rsp_valid), 64'h0);
    check_eq("rst_inflight", 64'(inflight), 64'h0);
    check_eq("rst_mul_A",    mul_A, 64'h0);
    check_eq("rst_mul_B",    mul_B, 64'h0);
    check_eq("rst_mul_rnd",  64'(mul_rnd), 64'h0);
    check_eq("rst_pookg",    64'(mul_pookg), 64'h0);
    check_eq("rst_rsp_id",   64'(bus.rsp_id), 64'h0);
    check_eq("rst_rsp_tag",  64'(bus.rsp_tag), 64'h0);
    bus.req_valid = '0;
    bus.req_rnd   = '0;
    bus.req_pookg = '0;
    #12 rst = 1'b0;
    next_cycle();

    // Single op 1.0 x 2.0 from requester 0
    set_req(2'd0, ONE, TWO, 1'b0, 1'b0, 4'd5);
    sample();
    check_eq("t1_ready", 64'(bus.req_ready), 64'h1);
    check_eq("t1_busy",  64'(busy), 64'h1);
    next_cycle(); clr_req(2'd0);
    sample();
    check_eq("t1_infl1", 64'(inflight), 64'h1);
    check_eq("t1_mul_A", mul_A, ONE);
    check_eq("t1_mul_B", mul_B, TWO);
    check_eq("t1_rsp0",  64'(bus.rsp_valid), 64'h0);
    next_cycle(); sample();
    check_eq("t1_rsp1",  64'(bus.rsp_valid), 64'h0);
    next_cycle(); sample();
    check_eq("t1_rsp_v",   64'(bus.rsp_valid), 64'h1);
    check_eq("t1_rsp_id",  64'(bus.rsp_id), 64'h0);
    check_eq("t1_rsp_tag", 64'(bus.rsp_tag), 64'h5);
    check_eq("t1_rsp_res", bus.rsp_res, TWO);
    check_eq("t1_pookg",   64'(mul_pookg), 64'h0);
    check_eq("t1_infl3",   64'(inflight), 64'h1);
    next_cycle(); sample();
    check_eq("t1_rsp_end", 64'(bus.rsp_valid), 64'h0);
    check_eq("t1_infl4",   64'(inflight), 64'h0);
    check_eq("t1_idle",    64'(busy), 64'h0);
    next_cycle();
    do_reset();

    // All four continuously valid: strict rotation, responses 3 cycles later
    for (int i = 0; i < 4; i++) set_req(2'(i), ONE, b_tab[i], 1'b0, 1'b0, 4'(i));
    for (int k = 0; k < 12; k++) begin
      sample();
      check_eq("t2_ready", 64'(bus.req_ready), (k < 8) ? (64'd1 << (k % 4)) : 64'd0);
      if (k >= 3 && k < 11) begin
        check_eq("t2_rsp_v",   64'(bus.rsp_valid), 64'h1);
        check_eq("t2_rsp_id",  64'(bus.rsp_id), 64'((k - 3) % 4));
        check_eq("t2_rsp_tag", 64'(bus.rsp_tag), 64'((k - 3) % 4));
        check_eq("t2_rsp_res", bus.rsp_res, b_tab[2'((k - 3) % 4)]);
      end else begin
        check_eq("t2_rsp_idle", 64'(bus.rsp_valid), 64'h0);
      end
      if (k == 5)  check_eq("t2_infl_max", 64'(inflight), 64'h3);
      if (k == 11) check_eq("t2_infl_end", 64'(inflight), 64'h0);
      next_cycle();
      if (k == 7) bus.req_valid = '0;
    end

    // Pointer steering: lone req1 -> ptr 2; then req1+req3 -> 3, 1; then req2
    set_req(2'd1, ONE, ONE, 1'b0, 1'b0, 4'd1);
    sample(); check_eq("t3_r1", 64'(bus.req_ready), 64'h2);
    next_cycle(); set_req(2'd3, ONE, ONE, 1'b0, 1'b0, 4'd3);
    sample(); check_eq("t3_r3_first", 64'(bus.req_ready), 64'h8);
    next_cycle(); clr_req(2'd3);
    sample(); check_eq("t3_r1_next", 64'(bus.req_ready), 64'h2);
    next_cycle(); clr_req(2'd1); set_req(2'd2, ONE, ONE, 1'b0, 1'b0, 4'd2);
    sample(); check_eq("t3_r2", 64'(bus.req_ready), 64'h4);
    next_cycle(); clr_req(2'd2);
    repeat (3) next_cycle();
    sample(); check_eq("t3_drained", 64'(inflight), 64'h0);
    next_cycle();

    // Three back-to-back ops from req0, then flush with req0+req2 asking
    set_req(2'd0, ONE, TWO, 1'b0, 1'b0, 4'd1);
    for (int k = 0; k < 3; k++) begin
      sample(); check_eq("t4_b2b", 64'(bus.req_ready), 64'h1);
      next_cycle();
    end
    set_req(2'd2, ONE, TWO, 1'b0, 1'b0, 4'd2);
    flush = 1'b1;
    sample();
    check_eq("t4_fl_ready", 64'(bus.req_ready), 64'h0);
    check_eq("t4_fl_infl",  64'(inflight), 64'h3);
    check_eq("t4_fl_rsp_v", 64'(bus.rsp_valid), 64'h1);
    check_eq("t4_fl_tag",   64'(bus.rsp_tag), 64'h1);
    next_cycle(); flush = 1'b0;
    sample();
    check_eq("t4_r2",       64'(bus.req_ready), 64'h4);
    check_eq("t4_infl0",    64'(inflight), 64'h0);
    check_eq("t4_killed1",  64'(bus.rsp_valid), 64'h0);
    next_cycle(); clr_req(2'd2);
    sample();
    check_eq("t4_r0",       64'(bus.req_ready), 64'h1);
    check_eq("t4_killed2",  64'(bus.rsp_valid), 64'h0);
    check_eq("t4_infl1",    64'(inflight), 64'h1);
    next_cycle(); clr_req(2'd0);
    sample(); check_eq("t4_gap", 64'(bus.rsp_valid), 64'h0);
    next_cycle(); sample();
    check_eq("t4_rsp2_v",  64'(bus.rsp_valid), 64'h1);
    check_eq("t4_rsp2_id", 64'(bus.rsp_id), 64'h2);
    next_cycle(); sample();
    check_eq("t4_rsp0_v",  64'(bus.rsp_valid), 64'h1);
    check_eq("t4_rsp0_id", 64'(bus.rsp_id), 64'h0);
    next_cycle(); sample();
    check_eq("t4_end", 64'(inflight), 64'h0);
    next_cycle();

    // Async reset mid-stream (pointer is 1 here)
    for (int i = 0; i < 4; i++) set_req(2'(i), ONE, b_tab[i], 1'b0, 1'b0, 4'(i));
    for (int k = 0; k < 3; k++) next_cycle();
    sample();
    check_eq("t5_pre_rsp_v",  64'(bus.rsp_valid), 64'h1);
    check_eq("t5_pre_rsp_id", 64'(bus.rsp_id), 64'h1);
    check_eq("t5_pre_infl",   64'(inflight), 64'h3);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_ar_ready", 64'(bus.req_ready), 64'h0);
    check_eq("t5_ar_rsp_v", 64'(bus.rsp_valid), 64'h0);
    check_eq("t5_ar_infl",  64'(inflight), 64'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    sample();
    check_eq("t5_first_grant", 64'(bus.req_ready), 64'h1);
    check_eq("t5_dropped0",    64'(bus.rsp_valid), 64'h0);
    next_cycle(); bus.req_valid = '0;
    sample(); check_eq("t5_dropped1", 64'(bus.rsp_valid), 64'h0);
    next_cycle(); sample(); check_eq("t5_dropped2", 64'(bus.rsp_valid), 64'h0);
    next_cycle(); sample();
    check_eq("t5_rsp_v",   64'(bus.rsp_valid), 64'h1);
    check_eq("t5_rsp_id",  64'(bus.rsp_id), 64'h0);
    check_eq("t5_rsp_res", bus.rsp_res, ONE);
    next_cycle();

    // Unnormalised 2.0 x 2.0: exponent 0x202 - 53 = 0x1CD
    set_req(2'd1, TWO, TWO, 1'b0, 1'b1, 4'd9);
    sample(); check_eq("t6_ready", 64'(bus.req_ready), 64'h2);
    next_cycle(); clr_req(2'd1);
    sample(); check_eq("t6_pookg_early1", 64'(mul_pookg), 64'h0);
    next_cycle(); sample(); check_eq("t6_pookg_early2", 64'(mul_pookg), 64'h0);
    next_cycle(); sample();
    check_eq("t6_pookg",   64'(mul_pookg), 64'h1);
    check_eq("t6_rsp_v",   64'(bus.rsp_valid), 64'h1);
    check_eq("t6_rsp_id",  64'(bus.rsp_id), 64'h1);
    check_eq("t6_rsp_tag", 64'(bus.rsp_tag), 64'h9);
    check_eq("t6_rsp_res", bus.rsp_res, 64'h39A0000000000000);
    next_cycle();

    // Rounding bit forwarded: 1.0 x 1.0 + rnd
    set_req(2'd2, ONE, ONE, 1'b1, 1'b0, 4'd3);
    sample(); check_eq("t7_ready", 64'(bus.req_ready), 64'h4);
    next_cycle(); clr_req(2'd2);
    sample(); check_eq("t7_mul_rnd", 64'(mul_rnd), 64'h1);
    next_cycle(); next_cycle(); sample();
    check_eq("t7_rsp_v",   64'(bus.rsp_valid), 64'h1);
    check_eq("t7_rsp_tag", 64'(bus.rsp_tag), 64'h3);
    check_eq("t7_rsp_res", bus.rsp_res, 64'h4000000000000001);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpuprod_sched.md
Name: fpuprod_sched

Overview:
Round-robin scheduler that shares one fpuprod64 multiplier between NREQ requesters. It arbitrates operand requests and registers the winner's operands into the multiplier. It carries requester ID and tag alongside the fixed-latency multiplier pipeline. It returns each product on a broadcast response bus with ID and tag.

Parameters:
NREQ, 4, number of requesters (2..16)
TAGW, 4, width of per-request tag carried through the pipe
LAT, 2, multiplier latency in clocks from operand presentation to valid res
IDW, $clog2(NREQ), requester ID width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  per-requester grant, one-hot or zero
req_A  in  NREQ*64  operand A, requester i at [64*i+:64]
req_B  in  NREQ*64  operand B
req_rnd  in  NREQ  rounding increment bit
req_pookg  in  NREQ  unnormalised-result select (exponent minus 53, low mantissa slice)
req_tag  in  NREQ*TAGW  requester-private tag
flush  in  1  synchronous kill of all in-flight operations
mul_A  out  64  operand A to multiplier (registered)
mul_B  out  64  operand B to multiplier (registered)
mul_rnd  out  1  rnd to multiplier (registered)
mul_pookg  out  1  pookg to multiplier, registered, delayed to match res
mul_res  in  64  multiplier result
rsp_valid  out  1  response valid
rsp_id  out  IDW  requester that issued the op
rsp_tag  out  TAGW  tag of the op
rsp_res  out  64  product (= mul_res)
inflight  out  $clog2(LAT+2)  count of issued, not yet returned ops
busy  out  1  inflight != 0 or any req_valid

Behaviour:
- Reset (async, immediate): rr_ptr=0, all stage valids=0, req_ready=0, rsp_valid=0, inflight=0, mul_A/mul_B=0, mul_rnd=0, mul_pookg=0, rsp_id=0, rsp_tag=0.
- Arbitration (combinational from registered rr_ptr): search req_valid starting at rr_ptr, wrapping modulo NREQ; first set index wins. req_ready[win]=1 only if req_valid[win]=1 and flush=0. All others are 0.
- Transfer = req_valid[i] & req_ready[i]. The requester holds valid and operands stable until transfer and may not withdraw valid.
- On transfer at edge t: rr_ptr <= win+1 (wraps NREQ-1 -> 0). The winner's A/B/rnd are registered onto mul_*. Stage-0 valid/id/tag/pookg are loaded. With no transfer, rr_ptr is unchanged, mul_A/mul_B/mul_rnd hold their value, and stage-0 valid=0.
- Operands appear at mul_* in cycle t+1. mul_res is valid in cycle t+1+LAT.
- Shift register of depth LAT+1 carries {valid,id,tag,pookg}. Its last stage drives rsp_valid/rsp_id/rsp_tag. mul_pookg is driven from the stage aligned with the multiplier's output mux (stage LAT).
- rsp_res = mul_res combinationally. Total grant-to-response latency is 1+LAT clocks, i.e. 3 with defaults.
- Issue rate: one op per clock, no bubbles, no backpressure. The response must be consumed in its valid cycle.
- flush=1 at an edge clears all stage valids and suppresses any grant that cycle. rsp_valid is 0 from the next cycle until new ops drain, and inflight becomes 0. If flush coincides with a would-be grant, no grant occurs and rr_ptr is unchanged.
- inflight: +1 on transfer, −1 when the last stage is valid. Both in the same cycle leave it unchanged. It never exceeds LAT+1.
- Single requester continuously valid gets a grant every cycle. All NREQ continuously valid are granted in strict rotation 0,1,..,NREQ-1,0.
- Reset asserted mid-operation drops in-flight ops with no response. Deassertion is synchronised externally.

Decomposition:
- Package fpuprod_pkg: FP_W=64, EXP_LSB=53, EXP_W=10, BIAS=10'h200, and a struct for the pipe entry {valid,id,tag,pookg}.
- One sub-module is natural: rr_arb (parameterised NREQ round-robin priority picker, req vector + pointer -> one-hot grant + index).
- The scheduler instantiates rr_arb. It does not instantiate fpuprod64; the bench and the top level connect it.

Test Plan:
- Reset then req0 with A=0x4000000000000000 (1.0), B=0x4020000000000000 (2.0), rnd=0, pookg=0, tag=5 -> req_ready[0] same cycle; rsp_valid 3 clocks later with id=0, tag=5, res=0x4020000000000000; inflight 1 -> 0.
- All 4 requesters valid for 8 cycles, tags = requester index -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; responses in identical order, 3 cycles offset, no gaps.
- req1 and req3 valid, rr_ptr=2 -> req3 granted first, then req1. Next lone req2 -> granted immediately.
- Issue 3 back-to-back ops, assert flush one cycle after the third grant with req2 valid -> no grant that cycle; no rsp_valid for the flushed ops; inflight=0; req2 granted the following cycle.
- Assert rst asynchronously mid-stream (between edges) -> req_ready, rsp_valid and inflight go 0 immediately; after release, first grant goes to requester 0.
- pookg=1 on a 2.0×2.0 op -> mul_pookg=1 in the same cycle mul_res is valid; rsp_res matches the multiplier model (exponent field 0x202−53).
